spike_event_arbiter: RTL and testbench
======================================

# spike_event_arbiter

Arbitrates between the two sparse spike-vector input streams that feed the synaptic array and serializes each accepted 32-bit vector into a stream of single-spike events. Each event is a bit index plus a source tag. It sits directly upstream of the synaptic array's weight lookup. The synaptic array can then process one spike per cycle instead of decoding whole vectors.

## Interface
Parameters:
- NBITS, 32, width of a sparse spike vector.
- IDXW, $clog2(NBITS) = 5, width of the event index (localparam, derived).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high. One clock; reset is asynchronous and active-high.
- ipt0_valid  in  1  port 0 vector valid.
- sparse_bits0  in  NBITS  port 0 spike vector; bit i set means spike on axon i.
- ipt0_ready  out  1  port 0 vector accepted when high together with ipt0_valid.
- ipt1_valid  in  1  port 1 vector valid.
- sparse_bits1  in  NBITS  port 1 spike vector.
- ipt1_ready  out  1  port 1 vector accepted when high together with ipt1_valid.
- evt_valid  out  1  event valid.
- evt_ready  in  1  downstream accepts the event.
- evt_idx  out  IDXW  index of the spiking bit.
- evt_src  out  1  source port of the event (0 or 1).
- evt_last  out  1  this event is the final set bit of its vector.
- busy  out  1  high whenever the state is SCAN.

## Operation
- FSM has two states: IDLE and SCAN.
- IDLE, grant rule:
  - grant0 = ipt0_valid & (!ipt1_valid | pref==0).
  - grant1 = ipt1_valid & !grant0.
  - ipt0_ready = IDLE & grant0; ipt1_ready = IDLE & grant1.
  - The two readys are never high together.
  - Readys are combinational from the valids, which is legal for a ready/valid handshake.
- IDLE, on handshake:
  - Latch the granted vector into `pend`; set src to the granted port.
  - Set pref to the other port (round-robin; the last winner loses the next tie).
- IDLE, next state:
  - Go to SCAN if the accepted vector is nonzero.
  - A zero vector is accepted and dropped; the FSM stays in IDLE and pref still toggles.
- SCAN, outputs:
  - evt_valid = 1; evt_idx = index of the lowest set bit of `pend`; evt_src = src.
  - evt_last = `pend` has exactly one bit set.
- SCAN, on evt_valid & evt_ready:
  - Clear the lowest set bit of `pend` (pend & (pend-1)).
  - If evt_last, return to IDLE.
- With no handshake, all event outputs hold stable. Required AXI-style stability.
- Events within a vector are emitted in ascending index order.

## Timing
- Reset (async, immediate) values: state=IDLE, pend=0, src=0, pref=0, evt_valid=0, evt_idx=0, evt_src=0, evt_last=0, busy=0.
- ipt*_ready is 0 while rst is high.
- Vector accepted at edge N gives the first event valid after edge N (cycle N+1); there is no combinational path from sparse_bits to evt_*.
- With evt_ready held high, a vector with k set bits occupies k+1 cycles: 1 accept cycle in IDLE plus k event cycles.
- A zero vector occupies 1 cycle.
- Inputs are not accepted during SCAN. This gives one bubble between vectors, which is accepted by design.
- When evt_ready is low, state and pend are frozen indefinitely; there is no timeout.
- Reset asserted mid-SCAN discards the remaining bits of `pend`. No partial event may appear after rst deasserts.
- Both ports valid continuously: grants strictly alternate, starting with port 0 after reset.

## Structure
- Shared package `snn_pkg`:
  - NBITS default constant.
  - State enum: IDLE=1'b0, SCAN=1'b1.
  - Event width constants, shared with the synaptic array's event input.
- Sub-module `lsb_index_enc`: purely combinational NBITS-to-IDXW lowest-set-bit encoder.
  - Outputs: index, `onehot` flag (exactly one bit set), and `zero` flag.
  - Instantiated once on `pend`; also used on the muxed input for the zero-vector check.
- The remainder, FSM, round-robin pointer and pend register, lives in spike_event_arbiter.

## Test plan
- Port 0 only, sparse_bits0=32'h0000_0091, evt_ready=1:
  - Events idx 0,4,7 with src=0 on consecutive cycles; evt_last only on idx 7.
  - ipt0_ready low for those 3 cycles.
- Right after reset, both valid (bits0=32'h1, bits1=32'h8000_0000):
  - Port 0 first (idx 0, last), then port 1 (idx 31, src=1, last).
  - Further simultaneous vectors alternate 0,1,0,1.
- Backpressure, vector 32'h0000_0006 with evt_ready low for 3 cycles:
  - evt_valid=1, idx=1, last=0 held stable for the full 3 cycles.
  - idx 2 follows only after the handshake.
- Zero vector on port 1: ipt1_ready pulses once, no evt_valid, busy stays 0, and pref flips to 0.
- 32'hFFFF_FFFF with evt_ready=1: 32 events idx 0..31, last only on 31, 33 cycles from accept to the next ipt ready.
- Reset asserted after 2 events of 32'hFFFF_0000 (idx 16,17 emitted):
  - evt_valid drops immediately.
  - After release, the FSM is IDLE, pend=0, and no idx 18 event appears.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network event path: vector width,
// event field widths and the arbiter state encoding.
package snn_pkg;

    localparam int SNN_NBITS = 32;
    localparam int SNN_IDXW  = $clog2(SNN_NBITS);
    // Event word seen by the synaptic array: index + source tag + last flag.
    localparam int SNN_EVT_W = SNN_IDXW + 2;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } arb_state_e;

endpackage

// File: rtl/spike_event_arbiter_if.sv
// Bundle of the two vector input streams, the event output stream and the
// busy indication. The arbiter takes the slave view, the feeding and
// consuming logic the master view.
interface spike_event_arbiter_if #(
    parameter int NBITS = snn_pkg::SNN_NBITS
);
    localparam int IDXW = $clog2(NBITS);

    logic             ipt0_valid;
    logic [NBITS-1:0] sparse_bits0;
    logic             ipt0_ready;
    logic             ipt1_valid;
    logic [NBITS-1:0] sparse_bits1;
    logic             ipt1_ready;
    logic             evt_valid;
    logic             evt_ready;
    logic [IDXW-1:0]  evt_idx;
    logic             evt_src;
    logic             evt_last;
    logic             busy;

    modport slave (
        input  ipt0_valid, sparse_bits0, ipt1_valid, sparse_bits1, evt_ready,
        output ipt0_ready, ipt1_ready, evt_valid, evt_idx, evt_src, evt_last, busy
    );

    modport master (
        output ipt0_valid, sparse_bits0, ipt1_valid, sparse_bits1, evt_ready,
        input  ipt0_ready, ipt1_ready, evt_valid, evt_idx, evt_src, evt_last, busy
    );

endinterface

// File: rtl/lsb_index_enc.sv
// Combinational lowest-set-bit encoder with one-hot and all-zero flags.
// An all-zero vector encodes to index 0.
module lsb_index_enc #(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0]         vec_i,
    output logic [$clog2(NBITS)-1:0] idx_o,
    output logic                     onehot_o,
    output logic                     zero_o
);
    localparam int IDXW = $clog2(NBITS);
    localparam logic [NBITS-1:0] ONE_V = {{(NBITS-1){1'b0}}, 1'b1};

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = {IDXW{1'b0}};
        for (int i = NBITS - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o = IDXW'(i);
            end else begin
                idx_o = idx_o;
            end
        end
    end

    // Flags: clearing the lowest bit leaves nothing exactly when one bit was set.
    always_comb begin
        zero_o   = (vec_i == {NBITS{1'b0}});
        onehot_o = !zero_o && ((vec_i & (vec_i - ONE_V)) == {NBITS{1'b0}});
    end

endmodule

// File: rtl/spike_event_arbiter.sv
// Round-robin arbiter between two sparse spike-vector ports that serializes
// each accepted vector into single-spike events in ascending index order.
module spike_event_arbiter
    import snn_pkg::*;
#(
    parameter int NBITS = SNN_NBITS
) (
    input  logic                  clk,
    input  logic                  rst,
    spike_event_arbiter_if.slave  bus
);
    localparam int IDXW = $clog2(NBITS);
    localparam logic [NBITS-1:0] ONE_V = {{(NBITS-1){1'b0}}, 1'b1};

    arb_state_e       state_q;
    // Bits still to be emitted after the event currently presented.
    logic [NBITS-1:0] pend_q;
    logic             src_q;
    logic             pref_q;
    logic [IDXW-1:0]  evt_idx_q;
    logic             evt_last_q;

    logic             grant0_s;
    logic             grant1_s;
    logic             ready0_s;
    logic             ready1_s;
    logic [NBITS-1:0] in_vec_s;
    logic [IDXW-1:0]  in_idx_s;
    logic             in_onehot_s;
    logic             in_zero_s;
    logic [IDXW-1:0]  pend_idx_s;
    logic             pend_onehot_s;
    logic             pend_zero_s;

    // Grant selection and combinational readys; nothing is accepted in reset.
    always_comb begin
        grant0_s = bus.ipt0_valid & (~bus.ipt1_valid | ~pref_q);
        grant1_s = bus.ipt1_valid & ~grant0_s;
        ready0_s = ~rst & (state_q == IDLE) & grant0_s;
        ready1_s = ~rst & (state_q == IDLE) & grant1_s;
        in_vec_s = grant1_s ? bus.sparse_bits1 : bus.sparse_bits0;
    end

    lsb_index_enc #(.NBITS(NBITS)) u_in_enc (
        .vec_i    (in_vec_s),
        .idx_o    (in_idx_s),
        .onehot_o (in_onehot_s),
        .zero_o   (in_zero_s)
    );

    lsb_index_enc #(.NBITS(NBITS)) u_pend_enc (
        .vec_i    (pend_q),
        .idx_o    (pend_idx_s),
        .onehot_o (pend_onehot_s),
        .zero_o   (pend_zero_s)
    );

    // FSM: accept a vector in IDLE, then step through its set bits in SCAN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= {NBITS{1'b0}};
            src_q      <= 1'b0;
            pref_q     <= 1'b0;
            evt_idx_q  <= {IDXW{1'b0}};
            evt_last_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ready0_s || ready1_s) begin
                        src_q  <= grant1_s;
                        // The winner loses the next tie.
                        pref_q <= grant0_s;
                        if (!in_zero_s) begin
                            state_q    <= SCAN;
                            evt_idx_q  <= in_idx_s;
                            evt_last_q <= in_onehot_s;
                            pend_q     <= in_vec_s & (in_vec_s - ONE_V);
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SCAN: begin
                    if (bus.evt_ready) begin
                        if (pend_zero_s) begin
                            state_q <= IDLE;
                        end else begin
                            evt_idx_q  <= pend_idx_s;
                            evt_last_q <= pend_onehot_s;
                            pend_q     <= pend_q & (pend_q - ONE_V);
                        end
                    end else begin
                        state_q <= SCAN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    pend_q  <= {NBITS{1'b0}};
                end
            endcase
        end
    end

    assign bus.ipt0_ready = ready0_s;
    assign bus.ipt1_ready = ready1_s;
    assign bus.evt_valid  = (state_q == SCAN);
    assign bus.busy       = (state_q == SCAN);
    assign bus.evt_idx    = evt_idx_q;
    assign bus.evt_src    = src_q;
    assign bus.evt_last   = evt_last_q;

endmodule

// File: tb/tb_spike_event_arbiter.sv
// Scoreboard bench for spike_event_arbiter: the driver predicts grants and
// queues expected events, a negedge monitor compares DUT outputs to them.
module tb_spike_event_arbiter;

    typedef struct {
        int idx;
        bit src;
        bit last;
    } evt_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    spike_event_arbiter_if #(.NBITS(32)) bus ();

    spike_event_arbiter #(.NBITS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    evt_t        exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    bit          exp_rdy0 = 1'b0;
    bit          exp_rdy1 = 1'b0;
    bit          pref     = 1'b0;
    bit          acc_valid = 1'b0;
    logic [31:0] acc_vec  = 32'h0;
    bit          acc_src  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: a vector becomes one event per set bit, ascending, last on the highest.
    task automatic push_vec(input logic [31:0] v, input bit src);
        int remaining;
        remaining = $countones(v);
        for (int i = 0; i < 32; i++) begin
            if (v[i]) begin
                evt_t e;
                remaining--;
                e.idx  = i;
                e.src  = src;
                e.last = (remaining == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    // One cycle: commit last edge's accept, drive new inputs, predict the grant.
    task automatic step(input bit v0, input logic [31:0] b0, input bit v1,
                        input logic [31:0] b1, input bit er);
        bit g0;
        bit g1;
        @(posedge clk);
        #1;
        if (acc_valid) begin
            push_vec(acc_vec, acc_src);
            acc_valid = 1'b0;
        end
        bus.ipt0_valid   = v0;
        bus.sparse_bits0 = b0;
        bus.ipt1_valid   = v1;
        bus.sparse_bits1 = b1;
        bus.evt_ready    = er;
        exp_rdy0 = 1'b0;
        exp_rdy1 = 1'b0;
        if (!rst && exp_q.size() == 0) begin
            g0 = v0 && (!v1 || !pref);
            g1 = v1 && !g0;
            exp_rdy0 = g0;
            exp_rdy1 = g1;
            if (g0 || g1) begin
                acc_valid = 1'b1;
                acc_vec   = g0 ? b0 : b1;
                acc_src   = g1;
                pref      = g0;
            end
        end
    endtask

    // Asynchronous reset pulse with both ports requesting; nothing may be accepted.
    task automatic do_reset(input int hold);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        acc_valid = 1'b0;
        pref      = 1'b0;
        exp_rdy0  = 1'b0;
        exp_rdy1  = 1'b0;
        bus.ipt0_valid = 1'b1;
        bus.ipt1_valid = 1'b1;
        bus.evt_ready  = 1'b1;
        #1;
        check("evt_valid_on_rst", {31'h0, bus.evt_valid}, 32'h0);
        repeat (hold) @(posedge clk);
        #1;
        bus.ipt0_valid = 1'b0;
        bus.ipt1_valid = 1'b0;
        rst = 1'b0;
    endtask

    // Let outstanding events drain, bounded.
    task automatic drain();
        int budget;
        budget = 200;
        while ((exp_q.size() != 0 || acc_valid) && budget > 0) begin
            step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
            budget--;
        end
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        check("drain_done", exp_q.size(), 32'h0);
    endtask

    function automatic logic [31:0] rand_vec();
        logic [31:0] v;
        case ($urandom_range(0, 4))
            0:       v = 32'h0;
            1:       v = 32'h1 << $urandom_range(0, 31);
            2:       v = $urandom & $urandom & $urandom;
            3:       v = $urandom;
            default: v = 32'hFFFF_FFFF;
        endcase
        return v;
    endfunction

    // Monitor: compare readys, valid/busy and the head expected event every cycle.
    always @(negedge clk) begin
        check("ipt0_ready", {31'h0, bus.ipt0_ready}, {31'h0, exp_rdy0});
        check("ipt1_ready", {31'h0, bus.ipt1_ready}, {31'h0, exp_rdy1});
        check("evt_valid", {31'h0, bus.evt_valid}, {31'h0, exp_q.size() != 0});
        check("busy", {31'h0, bus.busy}, {31'h0, exp_q.size() != 0});
        if (bus.evt_valid && exp_q.size() != 0) begin
            check("evt_idx", {27'h0, bus.evt_idx}, exp_q[0].idx);
            check("evt_src", {31'h0, bus.evt_src}, {31'h0, exp_q[0].src});
            check("evt_last", {31'h0, bus.evt_last}, {31'h0, exp_q[0].last});
            if (bus.evt_ready) begin
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bus.ipt0_valid   = 1'b1;
        bus.ipt1_valid   = 1'b1;
        bus.sparse_bits0 = 32'h0;
        bus.sparse_bits1 = 32'h0;
        bus.evt_ready    = 1'b1;
        #12;
        check("rst_evt_idx", {27'h0, bus.evt_idx}, 32'h0);
        check("rst_evt_src", {31'h0, bus.evt_src}, 32'h0);
        check("rst_evt_last", {31'h0, bus.evt_last}, 32'h0);
        bus.ipt0_valid = 1'b0;
        bus.ipt1_valid = 1'b0;
        rst = 1'b0;

        // Both ports valid after reset: port 0 first, then strict alternation.
        step(1'b1, 32'h0000_0001, 1'b1, 32'h8000_0000, 1'b1);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 32'h0000_0001 << i, 1'b1, 32'h8000_0000 >> i, 1'b1);
        end
        drain();

        // Port 0 only, three events.
        step(1'b1, 32'h0000_0091, 1'b0, 32'h0, 1'b1);
        repeat (4) step(1'b1, 32'h0000_0091, 1'b0, 32'h0, 1'b1);
        drain();

        // Backpressure: first event held for three cycles.
        step(1'b1, 32'h0000_0006, 1'b0, 32'h0, 1'b0);
        repeat (3) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        drain();

        // Zero vector on port 1, then a tie shows preference went back to port 0.
        step(1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0010, 1'b1, 32'h0000_0020, 1'b1);
        repeat (3) step(1'b1, 32'h0000_0010, 1'b1, 32'h0000_0020, 1'b1);
        drain();

        // Full vector: 32 events, then the next accept.
        step(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b1);
        repeat (34) step(1'b1, 32'h0000_0100, 1'b0, 32'h0, 1'b1);
        drain();

        // Reset mid-scan after idx 16 and 17 were emitted.
        step(1'b1, 32'hFFFF_0000, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        do_reset(3);
        repeat (4) step(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_0001, 1'b1, 32'h0000_0002, 1'b1);
        drain();

        // Randomized traffic with random backpressure.
        for (int n = 0; n < 1500; n++) begin
            step($urandom_range(0, 2) != 0, rand_vec(),
                 $urandom_range(0, 2) != 0, rand_vec(),
                 $urandom_range(0, 3) != 0);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
